// File: rtl/float32_pkg.sv
// Shared types and constants for the binary32 multiplier datapath.
package float32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Unpacked operand: significand MSB is always 1 for nonzero finite values.
    typedef struct packed {
        logic              sign;
        logic signed [9:0] exp;
        logic [23:0]       sig;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
        logic              is_snan;
    } operand_t;

    typedef enum logic [1:0] {
        CLS_FINITE,
        CLS_NAN,
        CLS_INF,
        CLS_ZERO
    } class_t;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lzc24 = 5'(23 - i);
        end
    endfunction

endpackage

// File: rtl/float32_unpack.sv
// Field extraction, classification and subnormal normalization of one operand.
module float32_unpack
    import float32_pkg::*;
(
    input  logic [31:0] op,
    output operand_t    unp
);

    logic [EXP_W-1:0]  exp_field;
    logic [FRAC_W-1:0] frac;
    logic [23:0]       raw_sig;
    logic [4:0]        lz;

    assign exp_field = op[30:23];
    assign frac      = op[22:0];
    assign raw_sig   = {(exp_field != '0), frac};
    assign lz        = lzc24(raw_sig);

    always_comb begin
        unp         = '0;
        unp.sign    = op[31];
        unp.is_zero = (exp_field == '0) && (frac == '0);
        unp.is_inf  = (exp_field == 8'hFF) && (frac == '0);
        unp.is_nan  = (exp_field == 8'hFF) && (frac != '0);
        unp.is_snan = unp.is_nan && !frac[22];
        // Subnormals sit at effective exponent 1; pull the MSB up and pay for it in the exponent.
        if (exp_field == '0) begin
            unp.sig = raw_sig << lz;
            unp.exp = 10'sd1 - $signed({5'b0, lz});
        end else begin
            unp.sig = raw_sig;
            unp.exp = $signed({2'b0, exp_field});
        end
    end

endmodule

// File: rtl/float32_multiplication.sv
// Two-stage binary32 multiplier: unpack/classify, then multiply, round (RNE) and pack.
module float32_multiplication
    import float32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    localparam int STAGES = 2;

    operand_t ua, ub;
    class_t   cls;
    logic     cls_invalid;

    logic [STAGES-1:0] vld_pipe;
    logic              s1_sign;
    logic signed [9:0] s1_exp_a, s1_exp_b;
    logic [23:0]       s1_sig_a, s1_sig_b;
    class_t            s1_cls;
    logic              s1_invalid;

    float32_unpack u_unpack_a (.op(a), .unp(ua));
    float32_unpack u_unpack_b (.op(b), .unp(ub));

    always_comb begin
        cls         = CLS_FINITE;
        cls_invalid = 1'b0;
        if (ua.is_nan || ub.is_nan) begin
            cls         = CLS_NAN;
            cls_invalid = ua.is_snan | ub.is_snan;
        end else if ((ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
            cls         = CLS_NAN;
            cls_invalid = 1'b1;
        end else if (ua.is_inf || ub.is_inf) begin
            cls = CLS_INF;
        end else if (ua.is_zero || ub.is_zero) begin
            cls = CLS_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1_sign    <= 1'b0;
            s1_exp_a   <= '0;
            s1_exp_b   <= '0;
            s1_sig_a   <= '0;
            s1_sig_b   <= '0;
            s1_cls     <= CLS_FINITE;
            s1_invalid <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
            if (in_valid) begin
                s1_sign    <= ua.sign ^ ub.sign;
                s1_exp_a   <= ua.exp;
                s1_exp_b   <= ub.exp;
                s1_sig_a   <= ua.sig;
                s1_sig_b   <= ub.sig;
                s1_cls     <= cls;
                s1_invalid <= cls_invalid;
            end
        end
    end

    logic [47:0]       prod, norm, shifted, lost_mask;
    logic signed [9:0] exp_n, exp_r;
    logic              tiny, g, r, s, inc;
    logic [5:0]        shamt;
    logic [23:0]       mant;
    logic [32:0]       packed_sum;
    logic [31:0]       res_n;
    logic              inv_n, ovf_n, unf_n, inx_n;

    always_comb begin
        prod  = {24'b0, s1_sig_a} * {24'b0, s1_sig_b};
        exp_n = s1_exp_a + s1_exp_b - 10'sd127;
        if (prod[47]) begin
            norm  = prod;
            exp_n = exp_n + 10'sd1;
        end else begin
            norm = prod << 1;
        end

        tiny  = (exp_n <= 10'sd0);
        shamt = 6'd0;
        if (tiny) shamt = (exp_n < -10'sd25) ? 6'd26 : 6'(10'sd1 - exp_n);
        shifted   = norm >> shamt;
        lost_mask = (48'd1 << shamt) - 48'd1;

        mant = shifted[47:24];
        g    = shifted[23];
        r    = shifted[22];
        s    = (|shifted[21:0]) | (|(norm & lost_mask));
        inc  = g & (r | s | mant[0]);

        // Rounding on {exponent, fraction} lets a mantissa carry bump the exponent,
        // including the subnormal-to-min-normal case.
        packed_sum = {(tiny ? 10'd0 : exp_n), mant[22:0]} + 33'(inc);
        exp_r      = $signed(packed_sum[32:23]);

        res_n = {s1_sign, packed_sum[30:0]};
        inv_n = 1'b0;
        ovf_n = 1'b0;
        inx_n = g | r | s;
        if (exp_r >= 10'sd255) begin
            res_n = {s1_sign, POS_INF[30:0]};
            ovf_n = 1'b1;
            inx_n = 1'b1;
        end
        unf_n = tiny & inx_n;

        case (s1_cls)
            CLS_NAN: begin
                res_n = QNAN;
                inv_n = s1_invalid;
                ovf_n = 1'b0;
                unf_n = 1'b0;
                inx_n = 1'b0;
            end
            CLS_INF, CLS_ZERO: begin
                res_n = (s1_cls == CLS_INF) ? {s1_sign, POS_INF[30:0]} : {s1_sign, 31'd0};
                ovf_n = 1'b0;
                unf_n = 1'b0;
                inx_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result         <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (vld_pipe[0]) begin
            result         <= res_n;
            flag_invalid   <= inv_n;
            flag_overflow  <= ovf_n;
            flag_underflow <= unf_n;
            flag_inexact   <= inx_n;
        end
    end

    assign out_valid = vld_pipe[STAGES-1];

endmodule

// File: tb/tb_float32_multiplication.sv
// Directed-vector bench for float32_multiplication; expected results hand-computed.
module tb_float32_multiplication;

    logic        clk = 1'b0;
    logic        rst_n, in_valid;
    logic [31:0] a, b, result;
    logic        out_valid, flag_invalid, flag_overflow, flag_underflow, flag_inexact;

    float32_multiplication dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .result(result),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;   // {invalid, overflow, underflow, inexact}
        int          due;
        int          id;
    } exp_t;

    exp_t q[$];
    bit   mon_en = 1'b0;
    int   n_issued = 0;

    task automatic apply(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vr, input logic [3:0] vf);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a = va;
        b = vb;
        e.res = vr; e.fl = vf; e.due = cyc + 2; e.id = n_issued;
        n_issued++;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("latency[%0d]", e.id), 64'(cyc), 64'(e.due));
                    check($sformatf("result_flags[%0d]", e.id),
                          {result, flag_invalid, flag_overflow, flag_underflow, flag_inexact},
                          {e.res, e.fl});
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check($sformatf("missing_out_valid[%0d]", e.id), 64'd0, 64'd1);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", {flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        apply(32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000);
        apply(32'h40400000, 32'h40800000, 32'h41400000, 4'b0000);
        apply(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);
        apply(32'hC0000000, 32'h40000000, 32'hC0800000, 4'b0000);
        apply(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        apply(32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        apply(32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
        apply(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
        apply(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
        apply(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        apply(32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 4'b0101);
        apply(32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000);
        apply(32'h00000001, 32'h3F000000, 32'h00000000, 4'b0011);
        apply(32'h00000003, 32'h3F000000, 32'h00000002, 4'b0011);
        apply(32'h00FFFFFF, 32'h3F000000, 32'h00800000, 4'b0011);
        apply(32'h00000001, 32'h00000001, 32'h00000000, 4'b0011);
        apply(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        apply(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        // Gap cycle must hold the previous output.
        a = 32'h40000000; b = 32'h40000000;

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        check("drain_pending", 64'(q.size()), 64'd0);
        @(negedge clk);
        check("hold_result", {result, flag_invalid, flag_overflow, flag_underflow, flag_inexact},
              {32'h80000000, 4'b0000});
        mon_en = 1'b0;

        @(negedge clk);
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000;
        @(negedge clk);
        a = 32'h40400000; b = 32'h40800000;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_out_valid[%0d]", i), 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
